// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative multiply / divide unit feeding a HI/LO register pair.
//
// Operations (op):
//   00 MULTU  unsigned a*b        -> HI = product[2W-1:W], LO = product[W-1:0]
//   01 MULT   signed   a*b        -> HI/LO as above, two's complement
//   10 DIVU   unsigned a/b        -> HI = remainder, LO = quotient
//   11 DIV    signed   a/b        -> quotient truncated toward zero,
//                                    remainder takes the sign of the dividend
// Division by zero writes HI = a, LO = all ones.
//
// Each operation runs on operand magnitudes. A start moves the FSM
// IDLE -> CALC. CALC runs WIDTH shift-add or shift-subtract steps. FIX
// applies the result signs. WB registers the write-back. done,
// we_hi and we_lo are therefore visible WIDTH+2 cycles after the edge that
// accepted start.
//
// Compile-time option:
//   MDU_DIV_EN  when defined, the divider datapath is built and DIVU/DIV are
//               accepted. When undefined, any start with op[1]=1 is ignored.
//
// Ports:
//   clk       clock, rising edge
//   clr       asynchronous active-low reset
//   start     operation request, honoured only when the unit is idle
//   op[1:0]   operation select (see above)
//   a, b      multiplicand/dividend and multiplier/divisor, sampled with start
//   busy      high from the cycle after acceptance through the done cycle
//   done      one-cycle completion pulse
//   we_hi     HI write enable (pulses with done)
//   we_lo     LO write enable (pulses with done)
//   hi_wdata  HI value, held between pulses
//   lo_wdata  LO value, held between pulses

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             we_hi,
    output logic             we_lo,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]        count_reg;
    logic [2*WIDTH-1:0]   acc_reg;      // product, or {remainder, quotient}
    logic [WIDTH-1:0]     opnd_reg;     // multiplicand or divisor magnitude
    logic                 neg_res_reg;  // product / quotient must be negated
    logic                 busy_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
`ifdef MDU_DIV_EN
    logic                 is_div_reg;
    logic                 neg_rem_reg;  // remainder must be negated
    logic                 div0_reg;
    logic [WIDTH-1:0]     a_reg;        // raw dividend, returned on divide by zero
`endif

    // ------------------------------------------------------------------
    // Operand preparation at start
    // ------------------------------------------------------------------
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;
    logic             last_iter;

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // busy also covers the done cycle, during which the FSM is already back
    // in IDLE; gating on busy keeps a start in that cycle from being taken.
`ifdef MDU_DIV_EN
    assign accept = (state_reg == IDLE) && start && !busy_reg;
`else
    assign accept = (state_reg == IDLE) && start && !busy_reg && !op[1];
`endif

    assign last_iter = (count_reg == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole register right,
    // keeping the carry as the new MSB.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    logic [2*WIDTH-1:0] step_val;

`ifdef MDU_DIV_EN
    // Divide (restoring): shift the next dividend bit into the remainder,
    // subtract the divisor when it fits, and shift the quotient bit in at
    // the bottom. The difference always fits in WIDTH bits when it is kept.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_step;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_reg});
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_reg;
    assign div_step  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        step_val = mul_step;
`ifdef MDU_DIV_EN
        if (is_div_reg) begin
            step_val = div_step;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Sign fix-up, result stored back as {HI, LO}
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] fix_val;

    always_comb begin
        fix_val = neg_res_reg ? -acc_reg : acc_reg;
`ifdef MDU_DIV_EN
        if (is_div_reg) begin
            if (div0_reg) begin
                fix_val = {a_reg, {WIDTH{1'b1}}};
            end else begin
                fix_val[2*WIDTH-1:WIDTH] = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                                       :  acc_reg[2*WIDTH-1:WIDTH];
                fix_val[WIDTH-1:0]       = neg_res_reg ? -acc_reg[WIDTH-1:0]
                                                       :  acc_reg[WIDTH-1:0];
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_reg   <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            neg_res_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MDU_DIV_EN
            is_div_reg  <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            a_reg       <= '0;
`endif
        end else begin
            done_reg <= (state_reg == WB);

            if (accept) begin
                busy_reg <= 1'b1;
            end else if (done_reg) begin
                busy_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        count_reg   <= '0;
                        neg_res_reg <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        is_div_reg  <= op[1];
                        neg_rem_reg <= a_neg;
                        div0_reg    <= (b == '0);
                        a_reg       <= a;
                        // Multiply: multiplier in the low half, multiplicand held.
                        // Divide: dividend in the low half, divisor held.
                        acc_reg     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        opnd_reg    <= op[1] ? b_mag : a_mag;
`else
                        acc_reg     <= {{WIDTH{1'b0}}, b_mag};
                        opnd_reg    <= a_mag;
`endif
                    end
                end
                CALC: begin
                    acc_reg   <= step_val;
                    count_reg <= count_reg + CW'(1);
                end
                FIX: begin
                    acc_reg <= fix_val;
                end
                WB: begin
                    hi_reg <= acc_reg[2*WIDTH-1:WIDTH];
                    lo_reg <= acc_reg[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign we_hi    = done_reg;
    assign we_lo    = done_reg;
    assign hi_wdata = hi_reg;
    assign lo_wdata = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (WIDTH=32). A behavioural model predicts
// busy/done/write-enables/HI/LO on every cycle from plain arithmetic; directed
// cases pin known results, latency, reset and the ignored-start rules, then a
// random phase issues random operations and stray starts.

module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, we_hi, we_lo;
    logic [W-1:0]  hi_wdata, lo_wdata;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    task automatic compute(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] h, output logic [W-1:0] l);
        logic [63:0] p;
        longint      ps;
        int          sx, sy, q, r;
        case (o)
            2'd0: begin
                p = {32'b0, x} * {32'b0, y};
                h = p[63:32]; l = p[31:0];
            end
            2'd1: begin
                ps = longint'($signed(x)) * longint'($signed(y));
                p  = ps;
                h = p[63:32]; l = p[31:0];
            end
            2'd2: begin
                if (y == 0) begin h = x; l = '1; end
                else begin h = x % y; l = x / y; end
            end
            default: begin
                if (y == 0) begin
                    h = x; l = '1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    h = '0; l = x;
                end else begin
                    sx = $signed(x); sy = $signed(y);
                    q = sx / sy; r = sx % sy;
                    h = r; l = q;
                end
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Cycle model: an accepted start produces done WIDTH+2 edges later;
    // busy covers the whole interval including the done cycle.
    // ------------------------------------------------------------------
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [W-1:0]  m_hi = '0, m_lo = '0;
    logic [W-1:0]  r_hi, r_lo;
    int            m_left = 0;
    logic [1:0]    t_op;
    logic [W-1:0]  t_a, t_b;

    always @(posedge clk) begin
        logic was_busy;
        if (!clr) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            was_busy = m_busy;
            m_done   = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1; m_hi = r_hi; m_lo = r_lo;
                    $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h", t_op, t_a, t_b, r_hi, r_lo);
                end
            end
            if (start && !was_busy && (DIV_EN || !op[1])) begin
                m_left = W + 2;
                t_op = op; t_a = a; t_b = b;
                compute(op, a, b, r_hi, r_lo);
            end
            m_busy = (m_left > 0) || m_done;
        end
    end

    // Per-cycle compare against the model
    always @(posedge clk) begin
        #2;
        total++;
        if ({busy, done, we_hi, we_lo, hi_wdata, lo_wdata} !==
            {m_busy, m_done, m_done, m_done, m_hi, m_lo}) begin
            bad++;
            $display("FAIL cycle_check t=%0t got busy=%b done=%b we=%b%b hi=%h lo=%h want busy=%b done=%b we=%b%b hi=%h lo=%h",
                     $time, busy, done, we_hi, we_lo, hi_wdata, lo_wdata,
                     m_busy, m_done, m_done, m_done, m_hi, m_lo);
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check32(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called at a falling edge; start is sampled by the next rising edge.
    task automatic drive_start(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Entered at the falling edge after the accepting edge (or exp_lat-adjusted).
    task automatic wait_done(input string name, input logic [W-1:0] eh, input logic [W-1:0] el,
                             input int exp_lat);
        int lat = 0;
        bit seen = 0;
        while (lat < 80 && !seen) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) seen = 1;
        end
        check32({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check32({name, "_latency"}, lat, exp_lat);
        check32({name, "_hi"}, hi_wdata, eh);
        check32({name, "_lo"}, lo_wdata, el);
        check32({name, "_busy_at_done"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        check32({name, "_busy_after"}, {31'b0, busy}, 32'd0);
        check32({name, "_done_after"}, {31'b0, done}, 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int viol;
        int dones;
        logic [1:0] op34;

        clr = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_done", {31'b0, done}, 32'd0);
        check32("reset_we", {30'b0, we_hi, we_lo}, 32'd0);
        check32("reset_hi", hi_wdata, 32'd0);
        check32("reset_lo", lo_wdata, 32'd0);
        clr = 1'b1;

        @(negedge clk);
        drive_start(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 34);

        @(negedge clk);
        drive_start(2'd1, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);

`ifdef MDU_DIV_EN
        @(negedge clk);
        drive_start(2'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);

        @(negedge clk);
        drive_start(2'd2, 32'd7, 32'd0);
        wait_done("divu_by0", 32'h0000_0007, 32'hFFFF_FFFF, 34);

        @(negedge clk);
        drive_start(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_overflow", 32'h0, 32'h8000_0000, 34);

        @(negedge clk);
        drive_start(2'd3, 32'hFFFF_FFF9, 32'd0);
        wait_done("div_by0_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 34);

        @(negedge clk);
        drive_start(2'd2, 32'd9, 32'd3);
        wait_done("divu_9by3", 32'h0, 32'd3, 34);
`else
        @(negedge clk);
        drive_start(2'd2, 32'd9, 32'd3);
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || done || we_hi || we_lo) viol++;
        end
        check32("nodiv_quiet", viol, 32'd0);
        @(negedge clk);
        drive_start(2'd0, 32'd9, 32'd3);
        wait_done("nodiv_multu_9x3", 32'h0, 32'd27, 34);
`endif

        // Start while busy is ignored
        @(negedge clk);
        drive_start(2'd0, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", 32'h0, 32'd12, 24);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check32("busy_ignore_single_done", dones, 32'd0);

        // Reset mid-operation, then start on the first edge after release
        op34 = DIV_EN ? 2'd2 : 2'd0;
        @(negedge clk);
        drive_start(op34, 32'd100, 32'd7);
        repeat (15) @(negedge clk);
        clr = 1'b0;
        #1;
        check32("midrst_busy", {31'b0, busy}, 32'd0);
        check32("midrst_done", {31'b0, done}, 32'd0);
        check32("midrst_hi", hi_wdata, 32'd0);
        check32("midrst_lo", lo_wdata, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        drive_start(2'd0, 32'd2, 32'd3);
        wait_done("after_rst_multu_2x3", 32'h0, 32'd6, 34);

        // Random operations with stray starts; the model checks every cycle
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO result width.
REQ-002 Port clk SHALL be an input, 1 bit wide; it is the single clock, and all state changes on its rising edge.
REQ-003 Port clr SHALL be an input, 1 bit wide; it is the reset, asynchronous and active-low.
REQ-004 Port start SHALL be an input, 1 bit wide; it is the operation request, sampled only in IDLE.
REQ-005 Port op SHALL be an input, 2 bits wide: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Ports a and b SHALL be inputs, WIDTH bits wide: a is the multiplicand or dividend, b the multiplier or divisor.
REQ-007 Port busy SHALL be an output, 1 bit wide; it is high from the cycle after start is accepted until done.
REQ-008 Port done SHALL be an output, 1 bit wide; it is a one-cycle completion pulse.
REQ-009 Ports we_hi and we_lo SHALL be outputs, 1 bit wide; they are the write enables to the HI/LO register pair.
REQ-010 Ports hi_wdata and lo_wdata SHALL be outputs, WIDTH bits wide; they carry the HI and LO values to write.

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX and WB.
  - IDLE->CALC on start=1.
  - CALC->FIX after exactly WIDTH iterations.
  - FIX->WB unconditionally.
  - WB->IDLE unconditionally.
REQ-012 On start in IDLE, the block SHALL latch op, a and b, plus the operand absolute values and result signs for signed ops; an iteration counter SHALL load to 0.
REQ-013 In CALC, multiply SHALL do one shift-add step per cycle on a 2*WIDTH-bit product register.
REQ-014 In CALC, divide SHALL do one restoring shift-subtract step per cycle, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
REQ-015 In FIX, signed ops SHALL apply the result signs, all arithmetic being two's complement modulo 2^WIDTH.
  - MULT: the product is negated if the operand signs differ.
  - DIV: the quotient is truncated toward zero; the remainder takes the sign of the dividend.
REQ-016 In WB, done, we_hi and we_lo SHALL all be 1 for exactly one cycle.
  - Multiply: hi_wdata = product[2*WIDTH-1:WIDTH], lo_wdata = product[WIDTH-1:0].
  - Divide: hi_wdata = remainder, lo_wdata = quotient.
REQ-017 Latency SHALL be fixed: done is asserted WIDTH+2 cycles after the clock edge that samples start.
REQ-018 When a done pulse is not being asserted, done, we_hi and we_lo SHALL be 0, and hi_wdata and lo_wdata SHALL hold their last values.
REQ-019 start SHALL be ignored while busy=1; the operation in flight is not disturbed, and operands SHALL NOT be re-latched.
REQ-020 start asserted in the WB cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-021 Divide by zero (b=0, DIVU or DIV) SHALL take the full latency and write hi_wdata=a and lo_wdata=all ones.
REQ-022 DIV with a=most-negative and b=-1 SHALL write lo_wdata=a and hi_wdata=0.
REQ-023 Operand inputs a and b SHALL be don't-care after the start cycle.

Reset
REQ-024 clr=0 SHALL asynchronously force the following, with no write or done pulse emitted:
  - FSM to IDLE;
  - busy, done, we_hi and we_lo to 0;
  - hi_wdata, lo_wdata, the counter and all internal registers to 0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation.
REQ-026 After clr deasserts, the first rising clk edge SHALL be able to accept start.

Configuration
REQ-027 With macro MDU_DIV_EN defined, all four ops SHALL be supported as specified.
REQ-028 With MDU_DIV_EN undefined, the divider datapath SHALL be omitted, and start with op[1]=1 SHALL be ignored: busy stays 0, done, we_hi and we_lo stay 0, and HI/LO are not written.
REQ-029 Multiply behaviour and latency SHALL be identical with and without MDU_DIV_EN.

Verification (WIDTH=32, MDU_DIV_EN defined unless noted)
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> 34 cycles later a one-cycle done with hi_wdata=0xFFFFFFFE, lo_wdata=0x00000001.
REQ-031 MULT a=0xFFFFFFFD (-3), b=5 -> hi_wdata=0xFFFFFFFF, lo_wdata=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7), b=2 -> lo_wdata=0xFFFFFFFD, hi_wdata=0xFFFFFFFF.
REQ-032 DIVU a=7, b=0 -> hi_wdata=0x00000007, lo_wdata=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo_wdata=0x80000000, hi_wdata=0.
REQ-033 Start MULTU 3*4, then pulse start with DIVU 9/2 at cycle 10 -> a single done with lo_wdata=12 and hi_wdata=0, and busy drops the cycle after done.
REQ-034 Start DIVU 100/7, then assert clr=0 at cycle 15 -> busy=0 immediately, no done, outputs 0; a following MULTU 2*3 gives lo_wdata=6.
REQ-035 With MDU_DIV_EN undefined, DIVU 9/3 -> busy, done and the write enables stay 0 for 40 cycles; a following MULTU 9*3 gives lo_wdata=27.
